// File: rtl/encoder_pkg.sv
// encoder_scan shared types: FSM state, scan-order constants, popcount.
// Imported by encoder_pick and encoder_scan.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int ENC_MODE_PRIO = 0;
  localparam int ENC_MODE_RR   = 1;

  // Callers zero-extend their vector to 64 bits.
  function automatic int popcount(input logic [63:0] v);
    int c;
    logic [63:0] t;
    c = 0;
    t = v;
    for (int i = 0; i < 64; i++) begin
      c = c + int'(t[0]);
      t = t >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/encoder_pick.sv
// Find-first-set over vec, searching upward from start with wrap.
// Ports: vec, start in; idx (first set index), found out.
module encoder_pick
  import encoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // One extra bit so start+i never overflows before the wrap.
  logic [IDX_W:0] j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      j = {1'b0, start} + (IDX_W+1)'(i);
      if (j >= (IDX_W+1)'(WIDTH))
        j = j - (IDX_W+1)'(WIDTH);
      if (!found && vec[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/encoder_scan.sv
// Captures a request vector and emits each set index over valid/ready.
// Ports: clk, rst_n, din/en/in_ready load side; dout/dout_valid/
// dout_ready/dout_last beat side; onehot and zero load flags.
module encoder_scan
  import encoder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH),
  parameter  int MODE  = ENC_MODE_PRIO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic             in_ready,
  output logic [IDX_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             onehot,
  output logic             zero
);

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick_idx;
  logic             found;
  logic             load;
  logic             beat;

  assign start = (MODE == ENC_MODE_RR) ? ptr : '0;

  encoder_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec   (pending),
    .start (start),
    .idx   (pick_idx),
    .found (found)
  );

  assign in_ready   = (state == IDLE);
  assign dout_valid = (state == SCAN);
  assign dout       = (dout_valid && found) ? pick_idx : '0;
  assign dout_last  = dout_valid &&
                      (popcount(64'(pending)) == 1);
  assign load       = in_ready && en;
  assign beat       = dout_valid && dout_ready;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (load && (din != '0)) nstate = SCAN;
      SCAN:    if (beat && dout_last) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      ptr     <= '0;
      onehot  <= 1'b0;
      zero    <= 1'b0;
    end else begin
      state <= nstate;
      zero  <= load && (din == '0);
      if (load)
        onehot <= (popcount(64'(din)) == 1);
      if (load && (din != '0)) begin
        pending <= din;
      end else if (beat) begin
        pending <= pending & ~(WIDTH'(1) << dout);
        // Explicit wrap keeps non-power-of-two widths in range.
        if (MODE == ENC_MODE_RR)
          ptr <= (dout == IDX_W'(WIDTH-1)) ? '0
               : dout + IDX_W'(1);
      end
    end
  end

endmodule
